// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multicycle issue/response wrapper around the combinational ALU.
// Optional feature macro: ALU_DIV_ZERO_TRAP_EN (trap divides with a zero divisor byte).
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  output logic [4:0]       alu_aluop,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_negative_flag,
  input  logic             alu_zero_flag,
  input  logic             alu_overflow_flag,
  input  logic             alu_carry_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       cnt;
  logic             accept;
  logic             op_illegal, op_mul, op_div, op_trap, op_bypass;
  logic [3:0]       lat_m1;

  always_comb begin
    op_illegal = (req_op == 5'b00000) || (req_op >= 5'b10100);
    op_mul     = (req_op == 5'b00100) || (req_op == 5'b00101);
    op_div     = (req_op == 5'b00110) || (req_op == 5'b00111);
`ifdef ALU_DIV_ZERO_TRAP_EN
    // The divider only looks at the low divisor byte, so that is what decides a trap.
    op_trap    = op_div && (req_b[7:0] == 8'h00);
`else
    op_trap    = 1'b0;
`endif
    op_bypass  = op_illegal || op_trap;
    if (op_mul)
      lat_m1 = 4'(MUL_LAT - 1);
    else if (op_div)
      lat_m1 = 4'(DIV_LAT - 1);
    else
      lat_m1 = 4'd0;
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_bypass ? RESP : EXEC;
      EXEC: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    alu_aluop = (state == EXEC) ? op_q : 5'b00000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        cnt  <= lat_m1;
        if (op_bypass) begin
          rsp_result <= '0;
          rsp_flags  <= op_trap ? 4'b0110 : 4'b0100;
          rsp_err    <= 1'b1;
        end
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          rsp_result <= alu_out;
          rsp_flags  <= {alu_negative_flag, alu_zero_flag, alu_overflow_flag, alu_carry_flag};
          rsp_err    <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign alu_in_1 = a_q;
  assign alu_in_2 = b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;
  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic [4:0]   req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err, busy;
  logic [W-1:0] alu_in_1, alu_in_2, alu_out;
  logic [4:0]   alu_aluop;
  logic         alu_n, alu_z, alu_v, alu_c;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_aluop(alu_aluop), .alu_out(alu_out),
    .alu_negative_flag(alu_n), .alu_zero_flag(alu_z), .alu_overflow_flag(alu_v), .alu_carry_flag(alu_c)
  );

  always #5 clk = ~clk;

  // Small ALU stand-in; opcode 0 yields a sentinel so a capture while idle is visible.
  logic signed [15:0] prod;
  always_comb begin
    alu_out = 32'hDEADBEEF;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    prod    = $signed(alu_in_1[7:0]) * $signed(alu_in_2[7:0]);
    case (alu_aluop)
      5'b00000: alu_v = 1'b1;
      5'b00001: {alu_c, alu_out} = {1'b0, alu_in_1} + {1'b0, alu_in_2};
      5'b00101: alu_out = {{16{prod[15]}}, prod};
      5'b00110, 5'b00111: begin
        if (alu_in_2[7:0] == 8'h00) begin
          alu_out = 32'hFFFFFFFF;
          alu_c   = 1'b1;
        end else begin
          alu_out = alu_in_1 / {24'h0, alu_in_2[7:0]};
        end
      end
      default: alu_out = alu_in_1 ^ alu_in_2;
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'h0);
  end

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid is seen; also counts cycles with a nonzero ALU opcode.
  task automatic wait_rsp(input logic [4:0] op, output int lat, output int nz, output int badop);
    lat = -1; nz = 0; badop = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
      if (alu_aluop != 5'b0) begin
        nz++;
        if (alu_aluop != op) badop++;
      end
      @(posedge clk);
    end
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if ({rsp_result, rsp_flags, rsp_err} !== 37'h0) begin errors++; $display("FAIL rst_rsp: got %h/%b/%b exp 0", rsp_result, rsp_flags, rsp_err); end
    checks++; if ({alu_in_1, alu_in_2, alu_aluop} !== 69'h0) begin errors++; $display("FAIL rst_alu: got %h/%h/%b exp 0", alu_in_1, alu_in_2, alu_aluop); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_add;
    int lat, nz, badop;
    issue(5'b00001, 32'd5, 32'd3);
    wait_rsp(5'b00001, lat, nz, badop);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d exp 1", lat); end
    checks++; if (nz !== 1 || badop !== 0) begin errors++; $display("FAIL add_aluop_cycles: got %0d/%0d exp 1/0", nz, badop); end
    checks++; if (rsp_result !== 32'h8) begin errors++; $display("FAIL add_result: got %h exp 00000008", rsp_result); end
    checks++; if (rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL add_flags: got %b/%b exp 0000/0", rsp_flags, rsp_err); end
    checks++; if (alu_in_1 !== 32'd5 || alu_in_2 !== 32'd3 || alu_aluop !== 5'b0) begin errors++; $display("FAIL add_alu_hold: got %h/%h/%b exp 5/3/0", alu_in_1, alu_in_2, alu_aluop); end
    handshake;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_after_hs: got valid %b ready %b exp 0/1", rsp_valid, req_ready); end
    checks++; if (rsp_result !== 32'h8) begin errors++; $display("FAIL add_result_kept: got %h exp 00000008", rsp_result); end
  endtask

  task automatic test_mul;
    int lat, nz, badop;
    issue(5'b00101, 32'h0000FFFD, 32'd4);
    wait_rsp(5'b00101, lat, nz, badop);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mul_latency: got %0d exp 2", lat); end
    checks++; if (nz !== 2 || badop !== 0) begin errors++; $display("FAIL mul_aluop_cycles: got %0d/%0d exp 2/0", nz, badop); end
    checks++; if (rsp_result !== 32'hFFFFFFF4) begin errors++; $display("FAIL mul_result: got %h exp fffffff4", rsp_result); end
    checks++; if (rsp_flags !== 4'b1000 || rsp_err !== 1'b0) begin errors++; $display("FAIL mul_flags: got %b/%b exp 1000/0", rsp_flags, rsp_err); end
    handshake;
  endtask

  task automatic test_div;
    int lat, nz, badop;
    issue(5'b00111, 32'd100, 32'd7);
    wait_rsp(5'b00111, lat, nz, badop);
    checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div_latency: got %0d exp %0d", lat, DIV_LAT); end
    checks++; if (nz !== DIV_LAT || badop !== 0) begin errors++; $display("FAIL div_aluop_cycles: got %0d/%0d exp %0d/0", nz, badop, DIV_LAT); end
    checks++; if (rsp_result !== 32'd14 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin errors++; $display("FAIL div_rsp: got %h/%b/%b exp 0000000e/0000/0", rsp_result, rsp_flags, rsp_err); end
    handshake;
  endtask

  task automatic test_backpressure;
    int lat, nz, badop;
    issue(5'b00011, 32'hF0, 32'h0F);
    wait_rsp(5'b00011, lat, nz, badop);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d exp 1", lat); end
    req_valid = 1'b1; req_op = 5'b00001; req_a = 32'h10; req_b = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF || rsp_flags !== 4'b0000 || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%b r%h f%b rdy%b busy%b exp v1 r000000ff f0000 rdy0 busy1", i, rsp_valid, rsp_result, rsp_flags, req_ready, busy);
      end
    end
    handshake;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs: got ready %b valid %b exp 1/0", req_ready, rsp_valid); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(5'b00001, lat, nz, badop);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bp_next_latency: got %0d exp 1", lat); end
    checks++; if (rsp_result !== 32'h30) begin errors++; $display("FAIL bp_next_result: got %h exp 00000030", rsp_result); end
    handshake;
  endtask

  task automatic test_illegal;
    logic [4:0] ops [2];
    int lat, nz, badop;
    ops[0] = 5'b10101;
    ops[1] = 5'b00000;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'h1234, 32'h5678);
      wait_rsp(ops[i], lat, nz, badop);
      checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency[%0d]: got %0d exp 0", i, lat); end
      checks++; if (nz !== 0 || alu_aluop !== 5'b0) begin errors++; $display("FAIL illegal_aluop[%0d]: got %0d cycles op %b exp 0", i, nz, alu_aluop); end
      checks++; if (rsp_result !== 32'h0 || rsp_flags !== 4'b0100 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp[%0d]: got %h/%b/%b exp 0/0100/1", i, rsp_result, rsp_flags, rsp_err); end
      handshake;
    end
  endtask

  task automatic test_div_zero;
    int lat, nz, badop;
    issue(5'b00110, 32'h1234, 32'h00000100);
    wait_rsp(5'b00110, lat, nz, badop);
`ifdef ALU_DIV_ZERO_TRAP_EN
    checks++; if (lat !== 0 || nz !== 0) begin errors++; $display("FAIL dz_trap_latency: got %0d/%0d exp 0/0", lat, nz); end
    checks++; if (rsp_result !== 32'h0 || rsp_flags !== 4'b0110 || rsp_err !== 1'b1) begin errors++; $display("FAIL dz_trap_rsp: got %h/%b/%b exp 0/0110/1", rsp_result, rsp_flags, rsp_err); end
`else
    checks++; if (lat !== DIV_LAT || nz !== DIV_LAT) begin errors++; $display("FAIL dz_latency: got %0d/%0d exp %0d", lat, nz, DIV_LAT); end
    checks++; if (rsp_result !== 32'hFFFFFFFF || rsp_flags !== 4'b1001 || rsp_err !== 1'b0) begin errors++; $display("FAIL dz_rsp: got %h/%b/%b exp ffffffff/1001/0", rsp_result, rsp_flags, rsp_err); end
`endif
    handshake;
  endtask

  task automatic test_reset_mid_op;
    int seen;
    issue(5'b00111, 32'd100, 32'd7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got v%b busy%b rdy%b exp 000", rsp_valid, busy, req_ready); end
    checks++; if ({alu_in_1, alu_in_2, alu_aluop} !== 69'h0 || {rsp_result, rsp_flags, rsp_err} !== 37'h0) begin errors++; $display("FAIL rmid_data: got %h/%h/%b %h/%b/%b exp 0", alu_in_1, alu_in_2, alu_aluop, rsp_result, rsp_flags, rsp_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b exp 1", req_ready); end
    seen = 0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d active cycles exp 0", seen); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_backpressure;
    test_illegal;
    test_div_zero;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential initiator for the combinational ALU. It accepts one operation request at a time over a valid/ready handshake and drives registered operands and opcode into the ALU. It waits a per-opcode number of cycles so the multiply and divide paths can settle, then captures the result and the N/Z/V/C flags into a response register held until the consumer accepts it. It sits between the datapath/decode stage and the ALU, and turns the ALU's single-cycle combinational path into a multicycle path.

## Interface
Parameters:
- WIDTH, 32, datapath width; must match the ALU width.
- MUL_LAT, 2, EXEC cycles for opcodes 00100/00101; legal range 1..15.
- DIV_LAT, 4, EXEC cycles for opcodes 00110/00111; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  5  aluop code.
- req_a  in  WIDTH  operand 1.
- req_b  in  WIDTH  operand 2.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_flags  out  4  {N,Z,V,C} captured flags.
- rsp_err  out  1  illegal opcode, or trapped divide (see Configuration).
- busy  out  1  state is not IDLE.
- alu_in_1, alu_in_2  out  WIDTH  registered operands to the ALU.
- alu_aluop  out  5  opcode to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_negative_flag, alu_zero_flag, alu_overflow_flag, alu_carry_flag  in  1  ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) and not rst. This is the only combinational output.
- IDLE:
  - On req_valid & req_ready, latch req_op/req_a/req_b into op_q/a_q/b_q.
  - Load a 4-bit counter with L-1.
  - Go to EXEC, or go to RESP directly for illegal or trapped ops.
- Latency L by opcode:
  - 00001–00011 and 01000–10011: L=1.
  - 00100/00101: L=MUL_LAT.
  - 00110/00111: L=DIV_LAT.
- Illegal opcodes: 00000 and 10100–11111.
  - Never issued to the ALU.
  - Go straight to RESP with result 0, flags 4'b0100, err=1.
- ALU drive:
  - alu_in_1 = a_q and alu_in_2 = b_q at all times. They stay stable from accept until the next accept.
  - alu_aluop = op_q in EXEC, 5'b00000 otherwise.
- EXEC:
  - The counter decrements each cycle.
  - In the cycle where the counter is 0: capture alu_out and the four flags into the response registers, set err=0, go to RESP.
- RESP:
  - rsp_valid=1. Result, flags and err are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_ready is ignored in every other state.
- One operation in flight at a time; requests do not overlap.
- rsp_result/rsp_flags/rsp_err keep their last value after the handshake until the next capture.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0, alu_in_1=0, alu_in_2=0, alu_aluop=0, req_ready=0 while rst is high, state=IDLE.
- Accept at rising edge k (req_valid & req_ready sampled high):
  - EXEC occupies cycles k+1..k+L.
  - rsp_valid rises at edge k+L+1.
  - Illegal or trapped ops: rsp_valid rises at edge k+1.
- Response handshake at edge m: req_ready is high from edge m. The next accept is possible at edge m+1.
- Minimum period per op: L+2 cycles.
- req_valid held high during EXEC/RESP: the request is not accepted and not lost. The requester must hold it stable.
- rst asserted mid-EXEC or mid-RESP: the operation is abandoned and rsp_valid drops immediately (asynchronous). No response is produced for that request.
- Counter wrap cannot occur; the legal parameter range is 1..15.

## Configuration
- Macro: ALU_DIV_ZERO_TRAP_EN.
- Defined:
  - Applies to opcode 00110/00111 with req_b[7:0]==0 (the divider uses an 8-bit divisor).
  - The op is not issued; the block goes straight to RESP.
  - Response: result 0, flags {N=0,Z=1,V=1,C=0}, err=1. rsp_valid rises at k+1.
- Undefined: divide-by-zero is issued normally with full DIV_LAT. Result and flags are whatever the ALU returns; err=0.

## Test plan
- Add: reset, then op 00001, a=5, b=3 -> rsp_valid at accept+2, result 32'h8, flags 4'b0000, err=0, alu_aluop=00001 only during the single EXEC cycle.
- Multiply: MUL_LAT=2, op 00101, a=32'h0000FFFD, b=4, ALU model returns 32'hFFFFFFF4 with N=1 -> rsp_valid at accept+3, flags 4'b1000. alu_aluop=00101 for exactly 2 cycles.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises -> result/flags stable, req_ready=0, a concurrent req_valid is not accepted. Next accept happens one cycle after the handshake.
- Illegal op 10101 -> no EXEC cycle, alu_aluop stays 0, rsp_valid at accept+1, result 0, flags 4'b0100, err=1.
- Divide by zero: op 00110, b=32'h00000100 (divisor byte 0).
  - With ALU_DIV_ZERO_TRAP_EN: rsp_valid at accept+1, flags 4'b0110, err=1.
  - Without the macro: rsp_valid at accept+DIV_LAT+1, err=0.
- Reset mid-op: op 00111 accepted, rst pulsed in the 2nd EXEC cycle -> all outputs at reset values immediately, no rsp_valid afterwards. req_ready=1 in the first cycle after rst is released.
